// File: rtl/arb_rr_lock.sv
// N-way round-robin arbiter. A grant stays locked to its owner until done, request drop, or hold-limit expiry.
// Every release passes through one idle cycle before the next grant.
module arb_rr_lock #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic [IDW-1:0] owner,
  output logic           expire
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int unsigned  NU        = N;
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t         state, state_nx;
  logic [N-1:0]   gnt_nx;
  logic [IDW-1:0] owner_nx, ptr, ptr_nx;
  logic [CW-1:0]  hold_cnt, hold_nx;
  logic           expire_nx;

  logic           found;
  logic [IDW-1:0] winner;
  logic           rel_done, rel_req, rel_to;

  // Scan ptr, ptr+1, ..., wrapping modulo N; first set request wins.
  always_comb begin : pick
    int unsigned    idx;
    logic [IDW-1:0] idx_s;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_s  = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NU) idx = idx - NU;
      idx_s = IDW'(idx);
      if (!found && req[idx_s]) begin
        found  = 1'b1;
        winner = idx_s;
      end
    end
  end

  always_comb begin
    rel_done = done[owner];
    rel_req  = !req[owner];
    rel_to   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  end

  always_comb begin
    state_nx  = state;
    gnt_nx    = gnt;
    owner_nx  = owner;
    ptr_nx    = ptr;
    hold_nx   = hold_cnt;
    expire_nx = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_nx = '0;
        if (found) begin
          gnt_nx[winner] = 1'b1;
          owner_nx       = winner;
          hold_nx        = '0;
          state_nx       = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_req || rel_to) begin
          gnt_nx    = '0;
          state_nx  = IDLE;
          hold_nx   = '0;
          ptr_nx    = (owner == IDW'(N - 1)) ? '0 : owner + 1'b1;
          // Done or request drop outranks the timeout, so expire only flags a pure timeout.
          expire_nx = rel_to && !rel_done && !rel_req;
        end else begin
          hold_nx = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      expire   <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      owner    <= owner_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      expire   <= expire_nx;
    end
  end

  assign busy = |gnt;

endmodule

// File: tb/tb_arb_rr_lock.sv
// Directed bench for arb_rr_lock (N=4, MAX_HOLD=16): vector table plus hand-written hold-limit,
// precedence and asynchronous-reset sequences.
module tb_arb_rr_lock;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, done, gnt;
  logic       busy, expire;
  logic [1:0] owner;

  int errors = 0;
  int checks = 0;

  arb_rr_lock #(.N(4), .IDW(2), .MAX_HOLD(16), .CW(5)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .busy(busy), .owner(owner), .expire(expire)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] owner;
  } vec_t;

  vec_t vecs[28];

  task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] eo, input logic ee);
    checks++;
    if (gnt !== eg || busy !== (|eg) || owner !== eo || expire !== ee) begin
      errors++;
      $display("FAIL %s: got gnt=%b busy=%b owner=%0d expire=%b, want gnt=%b busy=%b owner=%0d expire=%b",
               name, gnt, busy, owner, expire, eg, |eg, eo, ee);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // single requester, done at 5th edge
    vecs[0]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0};
    vecs[1]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0};
    vecs[2]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0};
    vecs[3]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0};
    vecs[4]  = '{4'b0001, 4'b0001, 4'b0000, 2'd0};
    vecs[5]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0};
    // rotation with all requesting, ptr=1
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1};
    vecs[7]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1};
    vecs[8]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1};
    vecs[9]  = '{4'b1111, 4'b0010, 4'b0000, 2'd1};
    vecs[10] = '{4'b1111, 4'b0000, 4'b0100, 2'd2};
    vecs[11] = '{4'b1111, 4'b0100, 4'b0000, 2'd2};
    vecs[12] = '{4'b1111, 4'b0000, 4'b1000, 2'd3};
    vecs[13] = '{4'b1111, 4'b1000, 4'b0000, 2'd3};
    vecs[14] = '{4'b1111, 4'b0000, 4'b0001, 2'd0};
    vecs[15] = '{4'b1111, 4'b0001, 4'b0000, 2'd0};
    // non-owner done/req ignored; owner request drop releases
    vecs[16] = '{4'b1111, 4'b0000, 4'b0010, 2'd1};
    vecs[17] = '{4'b1111, 4'b0100, 4'b0010, 2'd1};
    vecs[18] = '{4'b0111, 4'b0000, 4'b0010, 2'd1};
    vecs[19] = '{4'b1111, 4'b1000, 4'b0010, 2'd1};
    vecs[20] = '{4'b1101, 4'b0000, 4'b0000, 2'd1};
    vecs[21] = '{4'b1101, 4'b0000, 4'b0100, 2'd2};
    vecs[22] = '{4'b1101, 4'b0100, 4'b0000, 2'd2};
    // ptr=3: grant 1, drop with only 3 pending -> 3 next
    vecs[23] = '{4'b0010, 4'b0000, 4'b0010, 2'd1};
    vecs[24] = '{4'b1000, 4'b0000, 4'b0000, 2'd1};
    vecs[25] = '{4'b1000, 4'b0000, 4'b1000, 2'd3};
    vecs[26] = '{4'b0000, 4'b0000, 4'b0000, 2'd3};
    vecs[27] = '{4'b0000, 4'b0000, 4'b0000, 2'd3};

    rst  = 1'b1;
    req  = '0;
    done = '0;
    #3;
    chk("reset", 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      step(vecs[i].req, vecs[i].done);
      chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].owner, 1'b0);
    end

    // Hold limit: ptr=0, only req[2] -> granted for exactly 16 cycles.
    for (int i = 0; i < 16; i++) begin
      step(4'b0100, 4'b0000);
      chk($sformatf("hold%0d", i), 4'b0100, 2'd2, 1'b0);
    end
    step(4'b0100, 4'b0000);
    chk("expire", 4'b0000, 2'd2, 1'b1);
    step(4'b0100, 4'b0000);
    chk("regrant", 4'b0100, 2'd2, 1'b0);

    // Precedence: done arrives on the timeout edge.
    for (int i = 0; i < 15; i++) begin
      step(4'b0100, 4'b0000);
      chk($sformatf("prec_hold%0d", i), 4'b0100, 2'd2, 1'b0);
    end
    step(4'b0100, 4'b0100);
    chk("prec_release", 4'b0000, 2'd2, 1'b0);
    step(4'b0000, 4'b0000);
    chk("prec_idle", 4'b0000, 2'd2, 1'b0);

    // Async reset mid-grant, ptr=3.
    step(4'b1000, 4'b0000);
    chk("pre_rst_grant", 4'b1000, 2'd3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    step(4'b1010, 4'b0000);
    chk("post_rst_grant", 4'b0010, 2'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
